divider_restoring: RTL and testbench
====================================

Name: divider_restoring

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the wide multipliers in the modular-arithmetic datapath.
- Takes a double-width dividend, such as a full product, and a single-width divisor. Returns the full quotient and the remainder, one quotient bit per cycle.
- Used by the Barrett/Montgomery setup path, for constant precomputation (floor(2^k/m)) and for checking reductions. Throughput is not critical there.
- Handshake is start/busy/done, matching the multiplier's en-driven style.

Parameters:
- DIVIDEND_W, 160, dividend and quotient width in bits.
- DIVISOR_W, 80, divisor and remainder width in bits; must satisfy DIVISOR_W <= DIVIDEND_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  start strobe; sampled only when busy=0.
- dividend  input  DIVIDEND_W  numerator; sampled with en.
- divisor  input  DIVISOR_W  denominator; sampled with en.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse; quotient and remainder are valid.
- quotient  output  DIVIDEND_W  floor(dividend/divisor).
- remainder  output  DIVISOR_W  dividend mod divisor.
- div_zero  output  1  divisor was zero for the result being presented (see Optional Feature).

Behaviour:
- Reset (async, any time, including mid-operation):
  - busy, done, div_zero, quotient, remainder and all working registers go to 0.
  - State returns to IDLE; any in-flight operation is discarded.
- States: IDLE, RUN.
  - IDLE -> RUN on a clock edge with en=1. At that edge, latch the divisor, latch the dividend into the shift register, clear the partial remainder R (DIVISOR_W+1 bits), load the counter with DIVIDEND_W, and set busy=1.
  - RUN: on each edge:
    - Form trial = {R[DIVISOR_W-1:0], dividend MSB} and shift the dividend register left.
    - If trial >= divisor (no borrow on DIVISOR_W+1-bit subtract): R = trial - divisor and shift quotient bit 1 in at the LSB.
    - Otherwise R = trial and shift quotient bit 0 in.
    - Decrement the counter.
  - On the edge where the counter reaches 0 (the DIVIDEND_W-th RUN edge):
    - Copy the working quotient to quotient and R[DIVISOR_W-1:0] to remainder.
    - Set done=1 and busy=0; return to IDLE.
- Latency: en sampled at edge T0; done is high in the cycle after edge T0+DIVIDEND_W (160 cycles at default).
- done is a one-cycle pulse. quotient, remainder and div_zero are held stable until the next completion or reset.
- en while busy=1 is ignored: no restart, no corruption.
- en in the done cycle (busy=0) is accepted. Output registers keep the finished result until the new operation completes, because working registers are separate from output registers.
- Counter width: $clog2(DIVIDEND_W+1).
- No signed support; all arithmetic is modulo the stated widths.

Optional Feature:
- Macro DIV_ZERO_CHECK_EN.
- Defined:
  - At the accepting edge, divisor==0 skips RUN.
  - On the next edge: done=1, busy=0, quotient=all ones, remainder=dividend[DIVISOR_W-1:0], div_zero=1. Latency is 1 cycle.
  - div_zero clears to 0 on the next completion with a nonzero divisor.
- Not defined:
  - No detection; div_zero is tied 0.
  - A zero divisor runs the full DIVIDEND_W cycles through the normal algorithm. The result is quotient=all ones, remainder=dividend[DIVISOR_W-1:0] (truncated shift-in).
  - The quotient and remainder values are identical in both modes; only latency and the flag differ.

Test Plan:
- dividend=1000, divisor=7 -> quotient=142, remainder=6. done exactly 160 cycles after the en edge; busy high for the intervening cycles.
- dividend=2^160-1, divisor=2^80-1 -> quotient=2^80+1, remainder=0. Also dividend=(2^80-1)*(2^80-3), divisor=2^80-3 -> quotient=2^80-1, remainder=0.
- dividend=5, divisor=9 -> quotient=0, remainder=5. Also dividend=9, divisor=9 -> quotient=1, remainder=0.
- dividend=0x1234, divisor=0, macro defined -> done 1 cycle after en, quotient=all ones, remainder=0x1234, div_zero=1. Without the macro -> same quotient/remainder after 160 cycles, div_zero=0.
- Start 1000/7; pulse en with 50/5 at cycle 20 -> ignored, result 142/6. Then en with 50/5 in the done cycle -> previous outputs held until the next done presents 10/0.
- Start a division, assert rst at cycle 50 asynchronously (between edges) -> busy, done, quotient, remainder go to 0 immediately, with no done pulse afterwards. After release, 100/3 -> quotient=33, remainder=1.

Source files
------------

// File: rtl/divider_restoring.sv
// divider_restoring: multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst (async, active high)
//   en        : start strobe, sampled only while busy=0 (dividend/divisor latched with it)
//   busy      : division in progress
//   done      : one-cycle pulse, quotient/remainder/div_zero updated
//   quotient  : floor(dividend/divisor), DIVIDEND_W bits
//   remainder : dividend mod divisor, DIVISOR_W bits
//   div_zero  : zero divisor flag for the presented result
// Optional: define DIV_ZERO_CHECK_EN for a one-cycle zero-divisor shortcut with flag.
module divider_restoring #(
  parameter int unsigned DIVIDEND_W = 160,
  parameter int unsigned DIVISOR_W  = 80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_n;
  logic [DIVISOR_W-1:0]  dsr, dsr_n;
  logic [DIVIDEND_W-1:0] dvd, dvd_n;
  logic [DIVIDEND_W-1:0] quo, quo_n;
  logic [DIVISOR_W-1:0]  r, r_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  busy_n, done_n;
  logic [DIVIDEND_W-1:0] quotient_n;
  logic [DIVISOR_W-1:0]  remainder_n;
  logic [DIVISOR_W:0]    trial;
  logic                  ge;
  logic [DIVISOR_W-1:0]  sub;
`ifdef DIV_ZERO_CHECK_EN
  logic                  zero, zero_n;
  logic                  div_zero_n;
`endif

  // Partial remainder is kept DIVISOR_W wide: after each step it is below the
  // divisor, so the extra bit of the trial only matters for the compare, and the
  // low DIVISOR_W bits of the subtraction are exact whenever trial >= divisor.
  always_comb begin
    trial = {r, dvd[DIVIDEND_W-1]};
    ge    = (trial >= {1'b0, dsr});
    sub   = trial[DIVISOR_W-1:0] - dsr;

    state_n     = state;
    dsr_n       = dsr;
    dvd_n       = dvd;
    quo_n       = quo;
    r_n         = r;
    cnt_n       = cnt;
    busy_n      = busy;
    done_n      = 1'b0;
    quotient_n  = quotient;
    remainder_n = remainder;
`ifdef DIV_ZERO_CHECK_EN
    zero_n      = zero;
    div_zero_n  = div_zero;
`endif

    case (state)
      IDLE: begin
        if (en) begin
          dsr_n   = divisor;
          dvd_n   = dividend;
          quo_n   = '0;
          r_n     = '0;
          cnt_n   = CNT_W'(DIVIDEND_W);
          busy_n  = 1'b1;
          state_n = RUN;
`ifdef DIV_ZERO_CHECK_EN
          zero_n  = (divisor == '0);
`endif
        end
      end
      RUN: begin
`ifdef DIV_ZERO_CHECK_EN
        if (zero) begin
          quotient_n  = '1;
          remainder_n = dvd[DIVISOR_W-1:0];
          div_zero_n  = 1'b1;
          zero_n      = 1'b0;
          done_n      = 1'b1;
          busy_n      = 1'b0;
          state_n     = IDLE;
        end else begin
`else
        begin
`endif
          dvd_n = {dvd[DIVIDEND_W-2:0], 1'b0};
          quo_n = {quo[DIVIDEND_W-2:0], ge};
          r_n   = ge ? sub : trial[DIVISOR_W-1:0];
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            quotient_n  = quo_n;
            remainder_n = r_n;
            done_n      = 1'b1;
            busy_n      = 1'b0;
            state_n     = IDLE;
`ifdef DIV_ZERO_CHECK_EN
            div_zero_n  = 1'b0;
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dsr       <= '0;
      dvd       <= '0;
      quo       <= '0;
      r         <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_CHECK_EN
      zero      <= 1'b0;
      div_zero  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      dsr       <= dsr_n;
      dvd       <= dvd_n;
      quo       <= quo_n;
      r         <= r_n;
      cnt       <= cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      quotient  <= quotient_n;
      remainder <= remainder_n;
`ifdef DIV_ZERO_CHECK_EN
      zero      <= zero_n;
      div_zero  <= div_zero_n;
`endif
    end
  end

`ifndef DIV_ZERO_CHECK_EN
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divider_restoring.sv
module tb_divider_restoring;

  localparam int unsigned DW = 160;
  localparam int unsigned VW = 80;
`ifdef DIV_ZERO_CHECK_EN
  localparam int   ZLAT  = 1;
  localparam logic ZFLAG = 1'b1;
`else
  localparam int   ZLAT  = 160;
  localparam logic ZFLAG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy, done, div_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  int checks = 0;
  int errors = 0;

  divider_restoring #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk(clk), .rst(rst), .en(en), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: result from plain / and %, timing from the fixed latency.
  logic          m_busy, m_done, m_dz, p_dz;
  logic [DW-1:0] m_q, p_q, m_tmp;
  logic [VW-1:0] m_r, p_r;
  int            m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_q = '0; m_r = '0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r; m_dz = p_dz;
        end
      end else if (en) begin
        if (divisor == '0) begin
          p_q = '1; p_r = dividend[VW-1:0]; p_dz = ZFLAG; m_left = ZLAT;
        end else begin
          p_q   = dividend / {80'b0, divisor};
          m_tmp = dividend % {80'b0, divisor};
          p_r   = m_tmp[VW-1:0];
          p_dz  = 0;
          m_left = DW;
        end
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", DW'(busy), DW'(m_busy));
      chk("done", DW'(done), DW'(m_done));
      chk("quotient", quotient, m_q);
      chk("remainder", DW'(remainder), DW'(m_r));
      chk("div_zero", DW'(div_zero), DW'(m_dz));
    end
  end

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er, input string nm);
    int k;
    @(negedge clk);
    dividend = a; divisor = b; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_done(k);
    chk({nm, " latency"}, DW'(k), DW'((b == '0) ? ZLAT : 160));
    chk({nm, " q"}, quotient, eq);
    chk({nm, " r"}, DW'(remainder), DW'(er));
    chk({nm, " dz"}, DW'(div_zero), DW'((b == '0) ? ZFLAG : 1'b0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] x, y, a;
    logic [VW-1:0] b;
    int k;
    logic saw_done;

    rst = 1'b1; en = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", DW'(busy), '0);
    chk("reset done", DW'(done), '0);
    chk("reset q", quotient, '0);
    chk("reset r", DW'(remainder), '0);
    rst = 1'b0;

    do_div(160'd1000, 80'd7, 160'd142, 80'd6, "1000/7");

    a = '1; b = '1;
    do_div(a, b, (DW'(1) << 80) + DW'(1), 80'd0, "max/max");

    x = (DW'(1) << 80) - DW'(1);
    y = (DW'(1) << 80) - DW'(3);
    a = x * y;
    do_div(a, y[VW-1:0], x, 80'd0, "prod/factor");

    do_div(160'd5, 80'd9, 160'd0, 80'd5, "5/9");
    do_div(160'd9, 80'd9, 160'd1, 80'd0, "9/9");
    do_div(160'h1234, 80'd0, '1, 80'h1234, "0x1234/0");

    // asynchronous reset in the middle of a run
    @(negedge clk);
    dividend = 160'd1000; divisor = 80'd7; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", DW'(busy), '0);
    chk("async rst done", DW'(done), '0);
    chk("async rst q", quotient, '0);
    chk("async rst r", DW'(remainder), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (170) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("no done after reset", DW'(saw_done), '0);
    do_div(160'd100, 80'd3, 160'd33, 80'd1, "100/3");

    // en while busy is ignored; en in the done cycle is accepted
    @(negedge clk);
    dividend = 160'd1000; divisor = 80'd7; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (19) @(negedge clk);
    dividend = 160'd50; divisor = 80'd5; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_done(k);
    chk("ignore latency", DW'(k + 20), DW'(160));
    chk("ignore q", quotient, 160'd142);
    chk("ignore r", DW'(remainder), DW'(80'd6));
    dividend = 160'd50; divisor = 80'd5; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("held q", quotient, 160'd142);
    chk("restart busy", DW'(busy), DW'(1'b1));
    wait_done(k);
    chk("restart latency", DW'(k), DW'(160));
    chk("restart q", quotient, 160'd10);
    chk("restart r", DW'(remainder), '0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
